pong_core: RTL

Parametrised successor to the fixed-size game logic: a complete match engine that owns ball motion, paddle/wall collision, serving, scoring and match end. Instantiated once per design between the paddle modules and the display back-ends (`screen`, `vga`, `score`). Runs on one clock with a single-cycle `tick` enable from a `customclk` instance. Adds configurable field size, ball prescaler, serve delay, out-indication hold and win score.

---
 rtl/pong_core.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_core.sv
// pong_core: parametrised Pong match engine.
//
// Owns ball motion, wall and paddle collision, serving, scoring and match
// end. All state advances only on cycles where the single-cycle `tick`
// enable is high. All outputs come straight from registers.
//
// Ports
//   clk        : the only clock
//   reset      : synchronous, active-low
//   tick       : game-rate enable
//   start      : level; starts a serve from IDLE or OVER
//   entropy    : random bits; [0] picks serve direction, [2:1] pick dy
//   lpaddle    : left paddle row bitmap, bit r covers ball row r
//   rpaddle    : right paddle row bitmap
//   x, y       : ball column / row
//   out_left   : left player missed (held for OUT_HOLD ticks)
//   out_right  : right player missed (held for OUT_HOLD ticks)
//   score_p1   : left score
//   score_p2   : right score
//   winner     : 00 none, 01 p1, 10 p2
module pong_core #(
    parameter int FIELD_BITS  = 8,
    parameter int SPEED_DIV   = 4,
    parameter int SERVE_DELAY = 32,
    parameter int OUT_HOLD    = 64,
    parameter int WIN_SCORE   = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic [4:0]            entropy,
    input  logic [15:0]           lpaddle,
    input  logic [15:0]           rpaddle,
    output logic [FIELD_BITS-1:0] x,
    output logic [FIELD_BITS-1:0] y,
    output logic                  out_left,
    output logic                  out_right,
    output logic [3:0]            score_p1,
    output logic [3:0]            score_p2,
    output logic [1:0]            winner
);

    localparam int CNT_MAX = (SERVE_DELAY > OUT_HOLD) ? SERVE_DELAY : OUT_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int PRE_W   = $clog2(SPEED_DIV) + 1;

    localparam logic [FIELD_BITS-1:0] MAX_POS = '1;
    localparam logic [FIELD_BITS-1:0] CTR_POS = {1'b1, {(FIELD_BITS-1){1'b0}}};
    localparam logic [FIELD_BITS-1:0] ONE     = FIELD_BITS'(1);
    localparam logic [3:0]            WIN     = 4'(WIN_SCORE);

    // dy encoding mirrors entropy[2:1]; 2'b11 never stored.
    localparam logic [1:0] DY_ZERO = 2'b00;
    localparam logic [1:0] DY_POS  = 2'b01;
    localparam logic [1:0] DY_NEG  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_t;

    state_t                state_reg, state_next;
    logic [FIELD_BITS-1:0] x_reg, x_next;
    logic [FIELD_BITS-1:0] y_reg, y_next;
    logic                  dx_neg_reg, dx_neg_next;
    logic [1:0]            dy_reg, dy_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [PRE_W-1:0]      presc_reg, presc_next;
    logic                  out_left_reg, out_left_next;
    logic                  out_right_reg, out_right_next;
    logic [3:0]            score_p1_reg, score_p1_next;
    logic [3:0]            score_p2_reg, score_p2_next;
    logic [1:0]            winner_reg, winner_next;

    logic [3:0] row;
    logic [1:0] dy_entropy;
    logic       entropy_unused;

    assign row            = y_reg[FIELD_BITS-1:FIELD_BITS-4];
    assign dy_entropy     = (entropy[2:1] == 2'b11) ? DY_ZERO : entropy[2:1];
    assign entropy_unused = ^entropy[4:3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            x_reg         <= CTR_POS;
            y_reg         <= CTR_POS;
            dx_neg_reg    <= 1'b0;
            dy_reg        <= DY_ZERO;
            cnt_reg       <= '0;
            presc_reg     <= '0;
            out_left_reg  <= 1'b0;
            out_right_reg <= 1'b0;
            score_p1_reg  <= 4'd0;
            score_p2_reg  <= 4'd0;
            winner_reg    <= 2'b00;
        end else if (tick) begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            dx_neg_reg    <= dx_neg_next;
            dy_reg        <= dy_next;
            cnt_reg       <= cnt_next;
            presc_reg     <= presc_next;
            out_left_reg  <= out_left_next;
            out_right_reg <= out_right_next;
            score_p1_reg  <= score_p1_next;
            score_p2_reg  <= score_p2_next;
            winner_reg    <= winner_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        dx_neg_next    = dx_neg_reg;
        dy_next        = dy_reg;
        cnt_next       = cnt_reg;
        presc_next     = presc_reg;
        out_left_next  = out_left_reg;
        out_right_next = out_right_reg;
        score_p1_next  = score_p1_reg;
        score_p2_next  = score_p2_reg;
        winner_next    = winner_reg;

        case (state_reg)
            ST_IDLE: begin
                x_next = CTR_POS;
                y_next = CTR_POS;
                if (start) begin
                    state_next  = ST_SERVE;
                    dx_neg_next = ~entropy[0];
                    dy_next     = dy_entropy;
                    cnt_next    = '0;
                end
            end

            ST_SERVE: begin
                x_next = CTR_POS;
                y_next = CTR_POS;
                if (cnt_reg == CNT_W'(SERVE_DELAY - 1)) begin
                    state_next = ST_PLAY;
                    cnt_next   = '0;
                    presc_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_PLAY: begin
                if (presc_reg == PRE_W'(SPEED_DIV - 1)) begin
                    presc_next = '0;
                    // Y axis: reflect off top/bottom walls.
                    if (dy_reg == DY_NEG && y_reg == '0) begin
                        dy_next = DY_POS;
                        y_next  = ONE;
                    end else if (dy_reg == DY_POS && y_reg == MAX_POS) begin
                        dy_next = DY_NEG;
                        y_next  = MAX_POS - ONE;
                    end else if (dy_reg == DY_POS) begin
                        y_next = y_reg + ONE;
                    end else if (dy_reg == DY_NEG) begin
                        y_next = y_reg - ONE;
                    end
                    // X axis: paddle test uses the row before this step.
                    if (dx_neg_reg && x_reg == '0) begin
                        if (lpaddle[row]) begin
                            dx_neg_next = 1'b0;
                            x_next      = ONE;
                        end else begin
                            state_next    = ST_POINT;
                            out_left_next = 1'b1;
                            cnt_next      = '0;
                            if (score_p2_reg < WIN)
                                score_p2_next = score_p2_reg + 4'd1;
                        end
                    end else if (!dx_neg_reg && x_reg == MAX_POS) begin
                        if (rpaddle[row]) begin
                            dx_neg_next = 1'b1;
                            x_next      = MAX_POS - ONE;
                        end else begin
                            state_next     = ST_POINT;
                            out_right_next = 1'b1;
                            cnt_next       = '0;
                            if (score_p1_reg < WIN)
                                score_p1_next = score_p1_reg + 4'd1;
                        end
                    end else if (dx_neg_reg) begin
                        x_next = x_reg - ONE;
                    end else begin
                        x_next = x_reg + ONE;
                    end
                end else begin
                    presc_next = presc_reg + 1'b1;
                end
            end

            ST_POINT: begin
                if (cnt_reg == CNT_W'(OUT_HOLD - 1)) begin
                    cnt_next       = '0;
                    out_left_next  = 1'b0;
                    out_right_next = 1'b0;
                    x_next         = CTR_POS;
                    y_next         = CTR_POS;
                    if (score_p1_reg == WIN) begin
                        winner_next = 2'b01;
                        state_next  = ST_OVER;
                    end else if (score_p2_reg == WIN) begin
                        winner_next = 2'b10;
                        state_next  = ST_OVER;
                    end else begin
                        // Serve toward the player who just missed.
                        state_next  = ST_SERVE;
                        dx_neg_next = out_left_reg;
                        dy_next     = dy_entropy;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_OVER: begin
                x_next = CTR_POS;
                y_next = CTR_POS;
                if (start) begin
                    state_next    = ST_SERVE;
                    score_p1_next = 4'd0;
                    score_p2_next = 4'd0;
                    winner_next   = 2'b00;
                    dx_neg_next   = ~entropy[0];
                    dy_next       = dy_entropy;
                    cnt_next      = '0;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign x         = x_reg;
    assign y         = y_reg;
    assign out_left  = out_left_reg;
    assign out_right = out_right_reg;
    assign score_p1  = score_p1_reg;
    assign score_p2  = score_p2_reg;
    assign winner    = winner_reg;

endmodule
